// File: rtl/stream_flush_ctrl_pkg.sv
// ---------------------------------------------------------------------------
// stream_flush_pkg
//   Shared types and helpers for the stream flush controller.
//   - state_t   : controller FSM state encoding (2-bit)
//   - trig_byte : extracts byte k of the packed trigger sequence, where
//                 byte 0 is the first byte expected on the stream
//   - DEF_*     : default parameter values used by the controller
// ---------------------------------------------------------------------------
package stream_flush_pkg;

  localparam int          DEF_DATA_W         = 8;
  localparam int          DEF_TRIG_LEN       = 3;
  localparam logic [31:0] DEF_TRIG_SEQ       = 32'h00A55AC3;
  localparam int          DEF_FLUSH_CYCLES   = 16;
  localparam int          DEF_HOLDOFF_CYCLES = 8;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    FLUSH   = 2'd1,
    HOLDOFF = 2'd2
  } state_t;

  // Byte 0 is the most significant used byte of the packed sequence, so the
  // sequence reads left to right in the hex literal (A5, 5A, C3 by default).
  function automatic logic [7:0] trig_byte(input logic [31:0] seq,
                                           input int          len,
                                           input int          k);
    logic [31:0] shifted;
    shifted = seq >> (8 * (len - 1 - k));
    return shifted[7:0];
  endfunction

endpackage : stream_flush_pkg

// File: rtl/stream_flush_ctrl_seq_matcher.sv
// ---------------------------------------------------------------------------
// seq_matcher
//   Tracks how much of the trigger sequence has been seen on accepted beats
//   of a snooped valid/ready stream and pulses `hit` on the beat that
//   completes it.
//
// Ports:
//   clk     in   system clock, rising edge
//   rst     in   synchronous active-high reset
//   arm     in   matching enabled; when low the match index is held at 0
//   clr     in   clear the match index at the next edge
//   data_i  in   snooped stream data
//   vld_i   in   snooped stream valid
//   rdy_i   in   snooped stream ready (beat accepted when vld_i && rdy_i)
//   hit     out  one-cycle pulse: this cycle's accepted beat completes
//                the sequence (combinational, qualified by arm)
// ---------------------------------------------------------------------------
module seq_matcher
  import stream_flush_pkg::*;
#(
  parameter int          DATA_W   = DEF_DATA_W,
  parameter int          TRIG_LEN = DEF_TRIG_LEN,
  parameter logic [31:0] TRIG_SEQ = DEF_TRIG_SEQ
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              arm,
  input  logic              clr,
  input  logic [DATA_W-1:0] data_i,
  input  logic              vld_i,
  input  logic              rdy_i,
  output logic              hit
);

  localparam int IDX_W = (TRIG_LEN > 1) ? $clog2(TRIG_LEN) : 1;

  localparam logic [DATA_W-1:0] FIRST_BYTE =
    DATA_W'(trig_byte(TRIG_SEQ, TRIG_LEN, 0));
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(TRIG_LEN - 1);

  logic [IDX_W-1:0]  r_idx;
  logic [IDX_W-1:0]  w_idx_nxt;
  logic [DATA_W-1:0] w_exp_byte;
  logic              w_accept;
  logic              w_match;
  logic              w_last;

  assign w_accept   = vld_i && rdy_i;
  assign w_exp_byte = DATA_W'(trig_byte(TRIG_SEQ, TRIG_LEN, int'(r_idx)));
  // data_i only takes part in a compare on accepted beats, so an undriven
  // bus between beats never disturbs the index.
  assign w_match    = w_accept && (data_i == w_exp_byte);
  assign w_last     = (r_idx == LAST_IDX);
  assign hit        = arm && w_match && w_last;

  always_comb begin
    // NOTE: every signal written here gets a default first; a path that
    // leaves it unassigned would infer a latch.
    w_idx_nxt = r_idx;
    if (!arm || clr) begin
      w_idx_nxt = '0;
    end else if (w_accept) begin
      if (data_i == w_exp_byte) begin
        w_idx_nxt = w_last ? '0 : r_idx + IDX_W'(1);
      end else if (data_i == FIRST_BYTE) begin
        // Simple restart: a mismatching byte that equals the first trigger
        // byte starts a new attempt instead of dropping back to zero.
        w_idx_nxt = IDX_W'(1);
      end else begin
        w_idx_nxt = '0;
      end
    end
  end

  always_ff @(posedge clk) begin
    // NOTE: state registers use non-blocking assignments so every flop
    // samples the pre-edge values regardless of block ordering.
    if (rst) begin
      r_idx <= '0;
    end else begin
      r_idx <= w_idx_nxt;
    end
  end

endmodule : seq_matcher

// File: rtl/stream_flush_ctrl.sv
// ---------------------------------------------------------------------------
// stream_flush_ctrl
//   Drives the `flush` input of the stream pass-through stage. A flush window
//   of FLUSH_CYCLES starts either when a programmed trigger byte sequence is
//   seen on accepted beats, or when an explicit flush request is
//   acknowledged. Each window is followed by HOLDOFF_CYCLES during which
//   triggers and requests are ignored.
//
// Ports:
//   clk        in   system clock, rising edge
//   rst        in   synchronous active-high reset
//   en         in   arm enable for trigger detection and request acceptance
//   data_i     in   snooped stream data
//   vld_i      in   snooped stream valid
//   rdy_i      in   snooped stream ready
//   force_req  in   explicit flush request, held by requester until ack
//   force_ack  out  one-cycle pulse, request accepted (combinational)
//   flush      out  registered flush strobe to the pass-through stage
//   busy       out  high while in FLUSH or HOLDOFF
//   trig_cnt   out  flushes started by trigger, saturating at 255
// ---------------------------------------------------------------------------
module stream_flush_ctrl
  import stream_flush_pkg::*;
#(
  parameter int          DATA_W         = DEF_DATA_W,
  parameter int          TRIG_LEN       = DEF_TRIG_LEN,
  parameter logic [31:0] TRIG_SEQ       = DEF_TRIG_SEQ,
  parameter int          FLUSH_CYCLES   = DEF_FLUSH_CYCLES,
  parameter int          HOLDOFF_CYCLES = DEF_HOLDOFF_CYCLES
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              en,
  input  logic [DATA_W-1:0] data_i,
  input  logic              vld_i,
  input  logic              rdy_i,
  input  logic              force_req,
  output logic              force_ack,
  output logic              flush,
  output logic              busy,
  output logic [7:0]        trig_cnt
);

  localparam int CNT_MAX = (FLUSH_CYCLES > HOLDOFF_CYCLES) ? FLUSH_CYCLES
                                                           : HOLDOFF_CYCLES;
  localparam int CNT_W   = $clog2(CNT_MAX + 1);

  // The counter runs down to zero, so it is loaded with length-1 on entry.
  localparam logic [CNT_W-1:0] FLUSH_LOAD = CNT_W'(FLUSH_CYCLES - 1);
  localparam logic [CNT_W-1:0] HOLD_LOAD  =
    CNT_W'((HOLDOFF_CYCLES > 0) ? HOLDOFF_CYCLES - 1 : 0);

  state_t           r_state;
  state_t           w_state_nxt;
  logic [CNT_W-1:0] r_cnt;
  logic [CNT_W-1:0] w_cnt_nxt;
  logic             r_flush;
  logic [7:0]       r_trig_cnt;
  logic             w_arm;
  logic             w_hit;
  logic             w_force_ack;

  // Triggers and requests are only honoured while idle and enabled.
  assign w_arm       = (r_state == IDLE) && en;
  assign w_force_ack = w_arm && force_req;

  // Matcher index is forced to 0 whenever not armed, and also cleared when a
  // forced flush is accepted so a partial sequence does not survive it.
  seq_matcher #(
    .DATA_W   (DATA_W),
    .TRIG_LEN (TRIG_LEN),
    .TRIG_SEQ (TRIG_SEQ)
  ) u_seq_matcher (
    .clk    (clk),
    .rst    (rst),
    .arm    (w_arm),
    .clr    (w_force_ack),
    .data_i (data_i),
    .vld_i  (vld_i),
    .rdy_i  (rdy_i),
    .hit    (w_hit)
  );

  always_comb begin
    w_state_nxt = r_state;
    w_cnt_nxt   = r_cnt;
    unique case (r_state)
      IDLE: begin
        // A trigger and a request in the same cycle start a single window.
        if (w_hit || w_force_ack) begin
          w_state_nxt = FLUSH;
          w_cnt_nxt   = FLUSH_LOAD;
        end
      end
      FLUSH: begin
        if (r_cnt == '0) begin
          if (HOLDOFF_CYCLES > 0) begin
            w_state_nxt = HOLDOFF;
            w_cnt_nxt   = HOLD_LOAD;
          end else begin
            w_state_nxt = IDLE;
            w_cnt_nxt   = '0;
          end
        end else begin
          w_cnt_nxt = r_cnt - CNT_W'(1);
        end
      end
      HOLDOFF: begin
        if (r_cnt == '0) begin
          w_state_nxt = IDLE;
        end else begin
          w_cnt_nxt = r_cnt - CNT_W'(1);
        end
      end
      default: begin
        w_state_nxt = IDLE;
        w_cnt_nxt   = '0;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= IDLE;
      r_cnt   <= '0;
      r_flush <= 1'b0;
    end else begin
      r_state <= w_state_nxt;
      r_cnt   <= w_cnt_nxt;
      // Registered copy of "in FLUSH" so the strobe to the pass-through
      // stage comes straight from a flop.
      r_flush <= (w_state_nxt == FLUSH);
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_trig_cnt <= '0;
    end else if (w_hit && (r_trig_cnt != 8'hFF)) begin
      r_trig_cnt <= r_trig_cnt + 8'd1;
    end
  end

  assign force_ack = w_force_ack;
  assign flush     = r_flush;
  assign busy      = (r_state != IDLE);
  assign trig_cnt  = r_trig_cnt;

endmodule : stream_flush_ctrl

// File: tb/tb_stream_flush_ctrl.sv
// ---------------------------------------------------------------------------
// tb_stream_flush_ctrl
//   Scenario bench for stream_flush_ctrl with default parameters. Each test
//   builds a per-cycle stimulus list; for every cycle the expected outputs
//   are pushed to a scoreboard queue as the stimulus is driven and popped
//   and compared at the following falling edge.
// ---------------------------------------------------------------------------
module tb_stream_flush_ctrl;
  import stream_flush_pkg::*;

  localparam int FLUSH_N = 16;
  localparam int HOLD_N  = 8;

  logic       clk = 1'b0;
  logic       rst;
  logic       en;
  logic [7:0] data_i;
  logic       vld_i;
  logic       rdy_i;
  logic       force_req;
  logic       force_ack;
  logic       flush;
  logic       busy;
  logic [7:0] trig_cnt;

  always #5 clk = ~clk;

  stream_flush_ctrl #(
    .DATA_W         (8),
    .TRIG_LEN       (3),
    .TRIG_SEQ       (32'h00A55AC3),
    .FLUSH_CYCLES   (FLUSH_N),
    .HOLDOFF_CYCLES (HOLD_N)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .en        (en),
    .data_i    (data_i),
    .vld_i     (vld_i),
    .rdy_i     (rdy_i),
    .force_req (force_req),
    .force_ack (force_ack),
    .flush     (flush),
    .busy      (busy),
    .trig_cnt  (trig_cnt)
  );

  typedef struct packed {
    logic       rst;
    logic       en;
    logic       vld;
    logic       rdy;
    logic       req;
    logic [7:0] data;
  } stim_t;

  typedef struct packed {
    logic       flush;
    logic       busy;
    logic       ack;
    logic [7:0] tc;
  } exp_t;

  exp_t       exp_q[$];
  int         n_cmp = 0;
  int         n_bad = 0;
  logic [7:0] exp_tc = 8'd0;

  function automatic stim_t st(logic r, logic e, logic v, logic rd,
                               logic q, logic [7:0] d);
    stim_t s;
    s.rst = r; s.en = e; s.vld = v; s.rdy = rd; s.req = q; s.data = d;
    return s;
  endfunction

  function automatic stim_t beat(logic [7:0] d);
    return st(1'b0, 1'b1, 1'b1, 1'b1, 1'b0, d);
  endfunction

  function automatic stim_t idle_s();
    return st(1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 8'h00);
  endfunction

  function automatic bit in_win(int t, int fs, int len);
    return (fs >= 0) && (t >= fs) && (t < fs + len);
  endfunction

  // Expected outputs for cycle t given up to two flush window starts.
  function automatic exp_t mk_exp(int t, int fs_a, int fs_b, bit ack,
                                  logic [7:0] tc);
    exp_t e;
    e.flush = in_win(t, fs_a, FLUSH_N) || in_win(t, fs_b, FLUSH_N);
    e.busy  = in_win(t, fs_a, FLUSH_N + HOLD_N) ||
              in_win(t, fs_b, FLUSH_N + HOLD_N);
    e.ack   = ack;
    e.tc    = tc;
    return e;
  endfunction

  task automatic apply(input stim_t s);
    @(posedge clk);
    #1;
    rst       = s.rst;
    en        = s.en;
    vld_i     = s.vld;
    rdy_i     = s.rdy;
    force_req = s.req;
    data_i    = s.data;
  endtask

  task automatic test_reset();
    stim_t sq[$];
    exp_t  e, got;
    repeat (3) sq.push_back(st(1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 8'hA5));
    repeat (4) sq.push_back(idle_s());
    for (int t = 0; t < sq.size(); t++) begin
      apply(sq[t]);
      exp_q.push_back(mk_exp(t, -1, -1, 1'b0, 8'd0));
      @(negedge clk);
      got = {flush, busy, force_ack, trig_cnt};
      e   = exp_q.pop_front();
      n_cmp++;
      if (got !== e) begin
        n_bad++;
        $display("FAIL reset t=%0d got flush=%b busy=%b ack=%b tc=%0d want flush=%b busy=%b ack=%b tc=%0d",
                 t, got.flush, got.busy, got.ack, got.tc, e.flush, e.busy, e.ack, e.tc);
      end
    end
    exp_tc = 8'd0;
  endtask

  task automatic test_trigger();
    stim_t      sq[$];
    exp_t       e, got;
    logic [7:0] base = exp_tc;
    sq.push_back(beat(8'hA5));
    sq.push_back(beat(8'h5A));
    sq.push_back(beat(8'hC3));
    repeat (29) sq.push_back(idle_s());
    for (int t = 0; t < sq.size(); t++) begin
      apply(sq[t]);
      exp_q.push_back(mk_exp(t, 3, -1, 1'b0, (t >= 3) ? base + 8'd1 : base));
      @(negedge clk);
      got = {flush, busy, force_ack, trig_cnt};
      e   = exp_q.pop_front();
      n_cmp++;
      if (got !== e) begin
        n_bad++;
        $display("FAIL trigger t=%0d got flush=%b busy=%b ack=%b tc=%0d want flush=%b busy=%b ack=%b tc=%0d",
                 t, got.flush, got.busy, got.ack, got.tc, e.flush, e.busy, e.ack, e.tc);
      end
    end
    exp_tc = base + 8'd1;
  endtask

  // Restart on a repeated first byte plus a stalled beat, then a broken
  // sequence that must not trigger.
  task automatic test_restart_stall();
    stim_t      sq[$];
    exp_t       e, got;
    logic [7:0] base = exp_tc;
    sq.push_back(beat(8'hA5));
    sq.push_back(beat(8'hA5));
    sq.push_back(beat(8'h5A));
    sq.push_back(st(1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 8'h00));
    sq.push_back(beat(8'hC3));
    repeat (29) sq.push_back(idle_s());
    sq.push_back(beat(8'hA5));
    sq.push_back(beat(8'h5A));
    sq.push_back(beat(8'h00));
    sq.push_back(beat(8'hC3));
    repeat (4) sq.push_back(idle_s());
    for (int t = 0; t < sq.size(); t++) begin
      apply(sq[t]);
      exp_q.push_back(mk_exp(t, 5, -1, 1'b0, (t >= 5) ? base + 8'd1 : base));
      @(negedge clk);
      got = {flush, busy, force_ack, trig_cnt};
      e   = exp_q.pop_front();
      n_cmp++;
      if (got !== e) begin
        n_bad++;
        $display("FAIL restart t=%0d got flush=%b busy=%b ack=%b tc=%0d want flush=%b busy=%b ack=%b tc=%0d",
                 t, got.flush, got.busy, got.ack, got.tc, e.flush, e.busy, e.ack, e.tc);
      end
    end
    exp_tc = base + 8'd1;
  endtask

  // Request acked at once, then a request raised during HOLDOFF is acked on
  // the first IDLE cycle (back-to-back windows).
  task automatic test_force();
    stim_t sq[$];
    exp_t  e, got;
    for (int t = 0; t < 62; t++) begin
      if (t == 10 || (t >= 30 && t <= 35))
        sq.push_back(st(1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 8'h00));
      else
        sq.push_back(idle_s());
    end
    for (int t = 0; t < sq.size(); t++) begin
      apply(sq[t]);
      exp_q.push_back(mk_exp(t, 11, 36, (t == 10) || (t == 35), exp_tc));
      @(negedge clk);
      got = {flush, busy, force_ack, trig_cnt};
      e   = exp_q.pop_front();
      n_cmp++;
      if (got !== e) begin
        n_bad++;
        $display("FAIL force t=%0d got flush=%b busy=%b ack=%b tc=%0d want flush=%b busy=%b ack=%b tc=%0d",
                 t, got.flush, got.busy, got.ack, got.tc, e.flush, e.busy, e.ack, e.tc);
      end
    end
  endtask

  // Trigger and request in the same cycle, then a sequence during FLUSH.
  task automatic test_simultaneous();
    stim_t      sq[$];
    exp_t       e, got;
    logic [7:0] base = exp_tc;
    sq.push_back(beat(8'hA5));
    sq.push_back(beat(8'h5A));
    sq.push_back(st(1'b0, 1'b1, 1'b1, 1'b1, 1'b1, 8'hC3));
    sq.push_back(idle_s());
    sq.push_back(beat(8'hA5));
    sq.push_back(beat(8'h5A));
    sq.push_back(beat(8'hC3));
    repeat (23) sq.push_back(idle_s());
    for (int t = 0; t < sq.size(); t++) begin
      apply(sq[t]);
      exp_q.push_back(mk_exp(t, 3, -1, t == 2, (t >= 3) ? base + 8'd1 : base));
      @(negedge clk);
      got = {flush, busy, force_ack, trig_cnt};
      e   = exp_q.pop_front();
      n_cmp++;
      if (got !== e) begin
        n_bad++;
        $display("FAIL simultaneous t=%0d got flush=%b busy=%b ack=%b tc=%0d want flush=%b busy=%b ack=%b tc=%0d",
                 t, got.flush, got.busy, got.ack, got.tc, e.flush, e.busy, e.ack, e.tc);
      end
    end
    exp_tc = base + 8'd1;
  endtask

  // rst sampled during the fifth flush cycle kills the window next cycle.
  task automatic test_reset_mid_flush();
    stim_t      sq[$];
    exp_t       e, got;
    logic [7:0] base = exp_tc;
    sq.push_back(beat(8'hA5));
    sq.push_back(beat(8'h5A));
    sq.push_back(beat(8'hC3));
    repeat (4) sq.push_back(idle_s());
    sq.push_back(st(1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 8'h00));
    repeat (4) sq.push_back(idle_s());
    for (int t = 0; t < sq.size(); t++) begin
      apply(sq[t]);
      if (t >= 8)
        exp_q.push_back(mk_exp(t, -1, -1, 1'b0, 8'd0));
      else
        exp_q.push_back(mk_exp(t, 3, -1, 1'b0, (t >= 3) ? base + 8'd1 : base));
      @(negedge clk);
      got = {flush, busy, force_ack, trig_cnt};
      e   = exp_q.pop_front();
      n_cmp++;
      if (got !== e) begin
        n_bad++;
        $display("FAIL reset_mid t=%0d got flush=%b busy=%b ack=%b tc=%0d want flush=%b busy=%b ack=%b tc=%0d",
                 t, got.flush, got.busy, got.ack, got.tc, e.flush, e.busy, e.ack, e.tc);
      end
    end
    exp_tc = 8'd0;
  endtask

  // en=0 blocks triggers and requests and clears a partial match; a request
  // with en=1 afterwards is honoured.
  task automatic test_enable();
    stim_t sq[$];
    exp_t  e, got;
    sq.push_back(st(1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 8'hA5));
    sq.push_back(st(1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 8'h5A));
    sq.push_back(st(1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 8'hC3));
    repeat (3) sq.push_back(st(1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 8'h00));
    sq.push_back(st(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 8'h00));
    sq.push_back(beat(8'hA5));
    sq.push_back(beat(8'h5A));
    sq.push_back(st(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 8'h00));
    sq.push_back(beat(8'hC3));
    repeat (4) sq.push_back(idle_s());
    sq.push_back(st(1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 8'h00));
    repeat (26) sq.push_back(idle_s());
    for (int t = 0; t < sq.size(); t++) begin
      apply(sq[t]);
      exp_q.push_back(mk_exp(t, 16, -1, t == 15, exp_tc));
      @(negedge clk);
      got = {flush, busy, force_ack, trig_cnt};
      e   = exp_q.pop_front();
      n_cmp++;
      if (got !== e) begin
        n_bad++;
        $display("FAIL enable t=%0d got flush=%b busy=%b ack=%b tc=%0d want flush=%b busy=%b ack=%b tc=%0d",
                 t, got.flush, got.busy, got.ack, got.tc, e.flush, e.busy, e.ack, e.tc);
      end
    end
  endtask

  initial begin
    #100us;
    $display("FAIL watchdog expired at %0t", $time);
    $fatal(1, "watchdog");
  end

  initial begin
    rst       = 1'b1;
    en        = 1'b0;
    data_i    = 8'h00;
    vld_i     = 1'b0;
    rdy_i     = 1'b0;
    force_req = 1'b0;
    repeat (2) @(posedge clk);

    test_reset();
    test_trigger();
    test_restart_stall();
    test_force();
    test_simultaneous();
    test_reset_mid_flush();
    test_enable();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule : tb_stream_flush_ctrl

// File: doc/stream_flush_ctrl.md
Name: stream_flush_ctrl

Overview:
- Sequencer that drives the `flush` input of the stream tristate/pass-through stage on the 8-bit valid/ready byte stream.
- Snoops accepted beats upstream of that stage and detects a programmed trigger byte sequence. On detection it asserts `flush` for a fixed window, then enforces a hold-off before re-arming.
- Also accepts an explicit flush request over a req/ack handshake.
- Sits beside the pass-through stage; its `flush` output connects directly to that stage's `flush` input.

Parameters:
- DATA_W, 8, width of snooped data bus.
- TRIG_LEN, 3, number of bytes in the trigger sequence (range 1..4).
- TRIG_SEQ, 32'h00A55AC3, trigger bytes. Byte 0 (first expected) is TRIG_SEQ[8*TRIG_LEN-1 -: 8]. Default sequence is A5, 5A, C3.
- FLUSH_CYCLES, 16, number of cycles `flush` is held high (≥1).
- HOLDOFF_CYCLES, 8, number of cycles after flush during which triggers and requests are ignored (≥0).

Ports:
- clk  input  1  single system clock, all logic on rising edge.
- rst  input  1  reset, synchronous, active-high.
- en  input  1  arm enable; 0 disables trigger detection and force acceptance.
- data_i  input  DATA_W  snooped stream data.
- vld_i  input  1  snooped stream valid.
- rdy_i  input  1  snooped stream ready. A beat is accepted when vld_i && rdy_i.
- force_req  input  1  explicit flush request; requester holds it until force_ack.
- force_ack  output  1  one-cycle pulse, request accepted.
- flush  output  1  drives the pass-through stage; registered.
- busy  output  1  high in FLUSH or HOLDOFF.
- trig_cnt  output  8  number of flushes started by trigger (not force); saturates at 255.

Behaviour:
- Reset: sampled rst=1 gives state=IDLE, match index=0, all counters=0, flush=0, force_ack=0, busy=0, trig_cnt=0. Takes effect on the next edge even mid-FLUSH, so flush drops the cycle after rst is sampled.

States:
- IDLE:
  - Matching is active only when en=1.
  - On each accepted beat: if data_i==seq[idx], idx increments; else if data_i==seq[0], idx=1; else idx=0.
  - Non-accepted cycles leave idx unchanged.
  - A beat that completes the sequence (idx==TRIG_LEN-1 and match) → FLUSH; idx=0; trig_cnt++ (saturating).
- force_req=1 in IDLE with en=1 → force_ack=1 for that cycle (combinational from state/en/req), next state FLUSH, idx=0.
- Trigger completion and force_req in the same cycle → one FLUSH entry, force_ack pulses, trig_cnt increments.
- FLUSH:
  - flush=1 for exactly FLUSH_CYCLES consecutive cycles, starting the cycle after the triggering beat or ack.
  - Accepted beats are ignored; force_req is not acknowledged.
  - en falling mid-FLUSH does not shorten the window.
- HOLDOFF:
  - flush=0, busy=1 for HOLDOFF_CYCLES cycles; beats and requests are ignored.
  - If HOLDOFF_CYCLES=0, FLUSH goes directly to IDLE.
- en=0 in IDLE: idx cleared to 0 each cycle, no force_ack.
- Latency: completing beat or force ack at edge N gives flush=1 during cycles N+1 … N+FLUSH_CYCLES. The earliest next flush start is N+FLUSH_CYCLES+HOLDOFF_CYCLES+2.
- Counters are sized $clog2(max(FLUSH_CYCLES,HOLDOFF_CYCLES)+1). No wrap; each counter reloads on state entry.
- Matching uses the simple restart rule only (no full overlap search). This is exact for the default sequence.
- No X propagation: data_i is compared only when vld_i && rdy_i.

Decomposition:
- Package stream_flush_pkg:
  - state enum typedef {IDLE, FLUSH, HOLDOFF} (2-bit).
  - Function to extract trigger byte k from TRIG_SEQ.
  - Default constants.
- One natural sub-module: seq_matcher, containing the idx register and comparison. It outputs a one-cycle `hit` and takes a `clr` input.
- FSM and counters stay in the top module.

Test Plan:
- Reset/idle: hold rst 3 cycles, then release → flush=0, busy=0, force_ack=0, trig_cnt=0.
- Trigger: en=1, accepted beats A5,5A,C3 on consecutive cycles → flush=1 for exactly 16 cycles starting the cycle after C3, busy high for 24 cycles total, trig_cnt=1.
- Partial/restart and stall: beats A5,A5,5A,C3 with a vld_i=1, rdy_i=0 cycle inserted between 5A and C3 carrying 00 → one flush, trig_cnt=1. Beats A5,5A,00,C3 → no flush.
- Force handshake: force_req held from cycle 10 → force_ack pulse at cycle 10 only, flush cycles 11–26. A req raised during HOLDOFF is acked the first IDLE cycle (cycle 35).
- Simultaneous events: C3 completes the sequence in the same cycle as force_req → single 16-cycle flush, one force_ack, trig_cnt +1. A trigger sequence sent during FLUSH is ignored.
- Reset mid-flush and en: rst at flush cycle 5 → flush=0 the next cycle, trig_cnt=0. With en=0, sequence A5,5A,C3 and force_req → no flush, no ack.
